// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic job arbiter slice.
// State encodings, datapath widths and watchdog default.
package da_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ISSUE  = 3'd1;
  localparam state_t S_RUN    = 3'd2;
  localparam state_t S_RESULT = 3'd3;
  localparam state_t S_LOAD   = 3'd4;

  localparam int DA_ACCW    = 38;
  localparam int TAPW       = 64;
  localparam int DA_TIMEOUT = 64;

endpackage

// File: rtl/da_job_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request
// strictly after ptr_i, wrapping modulo NCH.
module rr_pick #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CHW-1:0] ptr_i,
  output logic [NCH-1:0] onehot_o,
  output logic [CHW-1:0] idx_o,
  output logic           any_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      for (int j = 0; j < NCH; j++) begin
        if (!any_o && req_i[j] &&
            j == (int'(ptr_i) + k) % NCH) begin
          any_o       = 1'b1;
          onehot_o[j] = 1'b1;
          idx_o       = CHW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/da_job_arbiter.sv
// Round-robin scheduler of the single DA FIR engine across
// NCH channels, with coefficient-load window and watchdog.
module da_job_arbiter
  import da_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int TIMEOUT = DA_TIMEOUT,
  parameter int ACCW    = DA_ACCW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*64-1:0] taps,
  output logic [NCH-1:0]    gnt,
  input  logic              cload_req,
  output logic              cload_gnt,
  output logic [63:0]       da_a,
  output logic              da_start,
  output logic              da_valid_in,
  output logic              da_cload,
  input  logic              da_done,
  input  logic [ACCW-1:0]   da_acc,
  output logic              res_valid,
  output logic [CHW-1:0]    res_ch,
  output logic [ACCW-1:0]   res_data,
  output logic              res_err,
  output logic              err_sticky,
  output logic              busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [CHW-1:0]  rr_q, rr_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [TAPW-1:0] da_a_q, da_a_d;
  logic [NCH-1:0]  gnt_q, gnt_d;
  logic            start_q, start_d;
  logic            vin_q, vin_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            rv_q, rv_d;
  logic [ACCW-1:0] rdata_q, rdata_d;
  logic            rerr_q, rerr_d;
  logic            err_q, err_d;

  logic [TAPW-1:0] tap_w [NCH];
  logic [NCH-1:0]  pick_oh;
  logic [CHW-1:0]  pick_idx;
  logic            pick_any;

  for (genvar g = 0; g < NCH; g++) begin : g_tap
    assign tap_w[g] = taps[g*TAPW +: TAPW];
  end

  rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
    .req_i    (req),
    .ptr_i    (rr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    da_a_d  = da_a_q;
    gnt_d   = '0;
    start_d = 1'b0;
    vin_d   = 1'b0;
    wdog_d  = wdog_q;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cload_req) begin
          state_d = S_LOAD;
        end else if (pick_any) begin
          gnt_d   = pick_oh;
          da_a_d  = tap_w[pick_idx];
          ch_d    = pick_idx;
          rr_d    = pick_idx;
          start_d = 1'b1;
          vin_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        vin_d   = 1'b1;
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        vin_d  = 1'b1;
        wdog_d = wdog_q + WDW'(1);
        // done on the first RUN cycle may be left over from the last job
        if (da_done && wdog_q != '0) begin
          rdata_d = da_acc;
          rerr_d  = 1'b0;
          rv_d    = 1'b1;
          vin_d   = 1'b0;
          state_d = S_RESULT;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          err_d   = 1'b1;
          rv_d    = 1'b1;
          vin_d   = 1'b0;
          state_d = S_RESULT;
        end
      end
      S_RESULT: state_d = S_IDLE;
      S_LOAD: begin
        if (!cload_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rr_q    <= CHW'(NCH - 1);
      ch_q    <= '0;
      da_a_q  <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      vin_q   <= 1'b0;
      wdog_q  <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      da_a_q  <= da_a_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      vin_q   <= vin_d;
      wdog_q  <= wdog_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      err_q   <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign cload_gnt   = (state_q == S_LOAD);
  assign da_cload    = cload_gnt;
  assign da_a        = da_a_q;
  assign da_start    = start_q;
  assign da_valid_in = vin_q;
  assign res_valid   = rv_q;
  assign res_ch      = ch_q;
  assign res_data    = rdata_q;
  assign res_err     = rerr_q;
  assign err_sticky  = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/da_job_arbiter.md
Name: da_job_arbiter

Overview:
- Schedules the single distributed-arithmetic FIR engine (da) among NCH sample channels.
- Each channel requests one filter evaluation by presenting its 8 packed 8-bit bit-slice addresses (A7..A0).
- The arbiter grants round-robin, drives the engine's start/valid_in/address inputs and waits for done, then returns ACC tagged with the channel index.
- Between jobs it also hands the engine's coefficient-load port (CLOAD) to a host loader. A watchdog aborts jobs whose done never arrives.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- CHW, 2, channel index width, equal to clog2(NCH).
- TIMEOUT, 64, maximum RUN cycles before a job is aborted.
- ACCW, 38, engine accumulator width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- req  in  NCH  per-channel job request, level; held until gnt.
- taps  in  NCH*64  per-channel packed {A7,...,A0}; channel i occupies bits [64i+63:64i].
- gnt  out  NCH  one-hot, 1-cycle pulse when the channel's job is accepted.
- cload_req  in  1  host requests the coefficient-load window.
- cload_gnt  out  1  high while the load window is open.
- da_a  out  64  packed {A7..A0} to the engine; held for the whole job.
- da_start  out  1  1-cycle start pulse.
- da_valid_in  out  1  high during RUN.
- da_cload  out  1  drives the engine's CLOAD; equals cload_gnt.
- da_done  in  1  engine done, level.
- da_acc  in  ACCW  engine ACC.
- res_valid  out  1  1-cycle result strobe.
- res_ch  out  CHW  channel index of the result.
- res_data  out  ACCW  captured ACC; forced to 0 on timeout.
- res_err  out  1  qualifies res_valid: the job timed out.
- err_sticky  out  1  set on any timeout; cleared only by reset.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (resetn=0 at posedge clk):
  - state=IDLE; all outputs 0; rr_ptr=NCH-1, so channel 0 wins first; wdog counter=0.
  - Reset mid-job abandons the job silently: no res_valid, no gnt.
- States: IDLE, ISSUE, RUN, RESULT, LOAD.
- IDLE:
  - If cload_req=1, go to LOAD. Loading has priority over pending jobs.
  - Otherwise, if any req bit is set, select the first set bit searching from rr_ptr+1 modulo NCH. Then: pulse gnt[sel], latch taps[sel] into da_a, latch sel into ch_reg, set rr_ptr=sel, go to ISSUE.
- ISSUE (1 cycle): da_start=1, da_valid_in=1; go to RUN with wdog=0.
- RUN:
  - da_valid_in=1; wdog increments each cycle.
  - da_done is ignored on the first RUN cycle, so a stale done from the previous job is never accepted.
  - From the second cycle on, da_done=1 captures da_acc into res_data and goes to RESULT with res_err=0.
  - If wdog reaches TIMEOUT-1 without done: res_data=0, res_err=1, err_sticky=1, go to RESULT.
  - Done and expiry in the same cycle: done wins.
- RESULT (1 cycle): res_valid=1, res_ch=ch_reg; go to IDLE. No back-to-back grant in this cycle.
  - Minimum job period is therefore 4 + engine latency cycles.
- LOAD:
  - cload_gnt=1 and da_cload=1; da_start=0, da_valid_in=0; pending req bits stay pending.
  - When cload_req=0, return to IDLE with cload_gnt low the next cycle.
  - cload_req rising during ISSUE/RUN/RESULT waits for IDLE; a running job is never preempted.
- A req bit that drops before it is granted is simply not served.
- gnt, da_start and res_valid are registered outputs.
- da_a changes only in the IDLE→ISSUE transition.
- rr_ptr is untouched by LOAD and by timeouts.

Decomposition:
- Shared package da_pkg holds:
  - state encodings: IDLE=3'd0, ISSUE=3'd1, RUN=3'd2, RESULT=3'd3, LOAD=3'd4;
  - ACCW and the 64-bit tap-word width;
  - TIMEOUT default.
- One sub-module, rr_pick: combinational round-robin selector (req, rr_ptr → onehot, index, any). It is reused by later multi-channel blocks.
- The FSM, watchdog and capture registers stay in da_job_arbiter.

Test Plan:
- Single job: req=4'b0001, taps[63:0]=64'h0102030405060708, engine model asserts done 20 cycles after start with acc=38'h12345 → gnt=0001 for 1 cycle; da_a=64'h0102030405060708; one da_start; res_valid with res_ch=0, res_data=38'h12345, res_err=0.
- Round-robin fairness: req=4'b1111 held, 8 jobs → grant order 0,1,2,3,0,1,2,3 and res_ch in the same order.
- Load priority: cload_req=1 with req=4'b0010 in IDLE → cload_gnt=1 and da_cload=1, no gnt. Drop cload_req → channel 1 granted 2 cycles later.
- No preemption: assert cload_req 5 cycles into RUN → cload_gnt stays 0 until RESULT completes, then rises 1 cycle after IDLE.
- Timeout: engine never raises done, TIMEOUT=64 → res_valid with res_err=1, res_data=0, err_sticky=1. The next job completes normally and err_sticky remains 1.
- Stale done and reset: hold da_done=1 across the start → it is ignored in the first RUN cycle and captured in the second. Assert resetn=0 mid-RUN → all outputs 0, no res_valid; the next grant goes to channel 0.
